aes128_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_inv_round.sv | 50 +++++
 rtl/aes128_inv_cipher_iter.sv | 131 +++++++++++++
 tb/tb_aes128_inv_cipher_iter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher.
// Holds the round count, the controller state encoding, the inverse S-box
// lookup and the GF(2^8) helpers used by InvMixColumns.
// Contents:
//   NR          - number of AES-128 rounds (10)
//   fsm_state_t - controller states IDLE / ROUND / DONE
//   inv_sbox()  - inverse S-box, 256-entry constant table
//   xtime()     - multiply by {02} modulo x^8+x^4+x^3+x+1
//   gmul()      - general GF(2^8) multiply built from xtime
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // Entry for byte value b sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return INV_SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant operand this collapses to
    // a few XOR levels.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES-128 decryption round, purely combinational.
// Order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
// with InvMixColumns bypassed on the last round.
// Ports:
//   state      in  128  current state, byte 0 in [127:120], column-major
//   rk         in  128  round key for this round
//   last       in  1    final round: skip InvMixColumns
//   next_state out 128  state after the round
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] ark;   // after shift, substitution and key add
    logic [127:0] mix;   // ark passed through InvMixColumns

    genvar gi;
    generate
        // Byte index i = row + 4*col. InvShiftRows rotates row r right by
        // r columns, so output column c takes input column (c - r) mod 4.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign ark[127-8*gi -: 8] = inv_sbox(state[127-8*SRC -: 8]) ^ rk[127-8*gi -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0;
            logic [7:0] a1;
            logic [7:0] a2;
            logic [7:0] a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign mix[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            assign mix[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            assign mix[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            assign mix[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    endgenerate

    assign next_state = last ? ark : mix;

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock.
// A ciphertext block is accepted in IDLE (whitened with round key 10),
// rounds 9..0 run in ROUND, and the plaintext is held in DONE until the
// consumer takes it. Round keys come from an external expanded-key store
// that answers rk_idx combinationally in the same cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush      in  1     abort in-flight block (only with AES128_INV_FLUSH_EN)
//   in_valid   in  1     ciphertext offered
//   in_ready   out 1     ready to accept (IDLE only)
//   in_data    in  128   ciphertext, byte 0 in [127:120], column-major
//   rk_idx     out 4     round-key index requested, 0..10
//   rk_data    in  128   round key for rk_idx
//   out_valid  out 1     plaintext available (DONE)
//   out_ready  in  1     consumer accepts plaintext
//   out_data   out 128   plaintext, same byte order as in_data
//   busy       out 1     high in ROUND or DONE
// Build option: define AES128_INV_FLUSH_EN to add the flush input.
module aes128_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES128_INV_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    fsm_state_t   fsm_reg;
    logic [127:0] state_reg;
    logic [3:0]   rnd_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [3:0]   rk_idx_reg;
    logic [127:0] round_next;
    logic         flush_req;

`ifdef AES128_INV_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    aes_inv_round u_round (
        .state      (state_reg),
        .rk         (rk_data),
        .last       (rnd_reg == 4'd0),
        .next_state (round_next)
    );

    // Handshake outputs and rk_idx are registered alongside the state so
    // they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            rnd_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rk_idx_reg    <= 4'(NR);
        end else begin
            case (fsm_reg)
                IDLE: begin
                    // A flush in IDLE simply blocks acceptance this cycle.
                    if (in_valid && !flush_req) begin
                        state_reg    <= in_data ^ rk_data;
                        rnd_reg      <= 4'(NR - 1);
                        rk_idx_reg   <= 4'(NR - 1);
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        fsm_reg      <= ROUND;
                    end
                end
                ROUND: begin
                    if (flush_req) begin
                        fsm_reg      <= IDLE;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        rk_idx_reg   <= 4'(NR);
                    end else begin
                        state_reg <= round_next;
                        if (rnd_reg == 4'd0) begin
                            fsm_reg       <= DONE;
                            out_valid_reg <= 1'b1;
                            rk_idx_reg    <= 4'(NR);
                        end else begin
                            rnd_reg    <= rnd_reg - 4'd1;
                            rk_idx_reg <= rnd_reg - 4'd1;
                        end
                    end
                end
                DONE: begin
                    // Flush and a completed output handshake both return
                    // to IDLE; either way out_valid drops.
                    if (flush_req || out_ready) begin
                        fsm_reg       <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        rk_idx_reg    <= 4'(NR);
                    end
                end
                default: begin
                    fsm_reg       <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                    rk_idx_reg    <= 4'(NR);
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign rk_idx    = rk_idx_reg;
    assign out_data  = state_reg;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Self-checking bench for aes128_inv_cipher_iter. Expected plaintexts are
// either FIPS-197 constants or produced by a forward-cipher model built
// here from GF(2^8) arithmetic (S-box derived from field inverses and the
// affine map), then fed back through the DUT as ciphertext.
module tb_aes128_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES128_INV_FLUSH_EN
    logic         flush;
`endif

    always #5 clk = ~clk;

    aes128_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES128_INV_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Expanded-key store answering in the same cycle.
    logic [127:0] rk_mem [0:10];
    always_comb begin
        rk_data = 128'h0;
        if (rk_idx <= 4'd10) rk_data = rk_mem[rk_idx];
    end

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (prod[k]) prod = prod ^ (15'h11b << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    logic [7:0] sbox_t [0:255];

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ rk_mem[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127-8*i -: 8]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ rk_mem[rnd];
        end
        return v;
    endfunction

    // ---------------- transaction ----------------
    // Offers ct, tracks latency and rk_idx order, checks pt, then holds
    // out_ready low for 'hold' cycles (poking in_valid meanwhile) before
    // completing the output handshake.
    task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int hold, input string tag);
        logic [43:0] seq_got;
        logic [43:0] seq_exp;
        int          lat;
        logic [127:0] result;
        seq_got = '0;
        seq_exp = '0;
        for (int k = 0; k <= 10; k++) seq_exp = {seq_exp[39:0], 4'(10 - k)};

        @(negedge clk);
        check_val({tag, ".in_ready_idle"}, in_ready, 1'b1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = ct;
        seq_got   = {seq_got[39:0], rk_idx};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        check_val({tag, ".busy"}, busy, 1'b1);
        check_val({tag, ".in_ready_busy"}, in_ready, 1'b0);

        lat = 0;
        while (!out_valid && lat < 40) begin
            seq_got = {seq_got[39:0], rk_idx};
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        result = out_data;
        check_val({tag, ".latency"}, 128'(lat), 128'd10);
        check_val({tag, ".rk_seq"}, 128'(seq_got), 128'(seq_exp));
        check_val({tag, ".pt"}, out_data, pt);

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == 3);
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                @(negedge clk);
                check_val({tag, ".hold_valid"}, out_valid, 1'b1);
                check_val({tag, ".hold_data"}, out_data, pt);
                check_val({tag, ".hold_in_ready"}, in_ready, 1'b0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_val({tag, ".post_valid"}, out_valid, 1'b0);
        check_val({tag, ".post_in_ready"}, in_ready, 1'b1);
        check_val({tag, ".post_busy"}, busy, 1'b0);
        $display("xfer %s ct=%h pt=%h lat=%0d hold=%0d", tag, ct, result, lat, hold);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val({tag, ".no_out_valid"}, 128'(seen), 128'd0);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;

        build_sbox();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES128_INV_FLUSH_EN
        flush     = 1'b0;
`endif
        for (int r = 0; r <= 10; r++) rk_mem[r] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset.in_ready", in_ready, 1'b1);
        check_val("reset.out_valid", out_valid, 1'b0);
        check_val("reset.busy", busy, 1'b0);
        check_val("reset.rk_idx", rk_idx, 4'd10);
        check_val("reset.out_data", out_data, 128'h0);
        rst_n = 1'b1;

        expand_key(C1_KEY);
        do_block(C1_CT, C1_PT, 0, "c1");
        expand_key(B_KEY);
        do_block(B_CT, B_PT, 0, "appb");
        expand_key(C1_KEY);
        do_block(C1_CT, C1_PT, 20, "backpressure");

        for (int n = 0; n < 10; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            ct = model_encrypt(pt);
            do_block(ct, pt, int'($urandom_range(0, 2)), "random");
        end

        // Reset while round 5 is pending.
        expand_key(C1_KEY);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rk_idx != 4'd5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("rst.reach_round5", rk_idx, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst.in_ready", in_ready, 1'b1);
        check_val("rst.out_valid", out_valid, 1'b0);
        check_val("rst.busy", busy, 1'b0);
        check_val("rst.rk_idx", rk_idx, 4'd10);
        check_val("rst.out_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("rst", 15);
        $display("xfer reset_mid_round discarded");
        do_block(C1_CT, C1_PT, 0, "c1_after_rst");

`ifdef AES128_INV_FLUSH_EN
        // Flush during round 3.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rk_idx != 4'd3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("flush.reach_round3", rk_idx, 4'd3);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_val("flush.in_ready", in_ready, 1'b1);
        check_val("flush.busy", busy, 1'b0);
        check_val("flush.out_valid", out_valid, 1'b0);
        watch_no_valid("flush", 15);
        $display("xfer flush_round3 discarded");

        // Flush in IDLE blocks acceptance.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = C1_CT;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("flush_idle.busy", busy, 1'b0);
        check_val("flush_idle.in_ready", in_ready, 1'b1);
        $display("xfer flush_idle blocked");

        expand_key(B_KEY);
        do_block(B_CT, B_PT, 0, "appb_after_flush");
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
